// File: rtl/ifetch_issue.sv
// Instruction fetch/issue stage: walks the PC, fetches words over a req/ack port,
// queues them in a small FIFO and hands opcode/func/imm/PC to the decoder.
module ifetch_issue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [15:0]       imm16,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              drop_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [ADDR_W+31:0] fifo_q [DEPTH];

  logic              push;
  logic              pop;
  logic [CW-1:0]     count_after;
  logic              has_room;
  logic [ADDR_W+31:0] head;

  // A branch in flight hides the head so the decoder never consumes a stale entry.
  always_comb begin
    dec_valid   = (count_q != '0) && !branch_taken;
    pop         = dec_valid && dec_ready;
    push        = (state_q == REQ) && imem_ack && !drop_q && !branch_taken;
    count_after = count_q + CW'(push) - CW'(pop);
    has_room    = count_after < CW'(DEPTH);
  end

  assign head      = fifo_q[rd_ptr_q];
  assign instr     = head[31:0];
  assign instr_pc  = head[ADDR_W+31:32];
  assign opcode    = instr[31:26];
  assign func      = instr[5:0];
  assign imm16     = instr[15:0];
  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_q[wr_ptr_q] <= {addr_q, imem_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= '0;
      drop_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (branch_taken) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_after;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      case (state_q)
        IDLE: begin
          if (branch_taken) begin
            pc_q <= branch_target;
          end else if (has_room) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (!imem_ack) begin
            // Request must stay stable; remember to throw its word away.
            if (branch_taken) begin
              drop_q <= 1'b1;
              pc_q   <= branch_target;
            end
          end else if (drop_q || branch_taken) begin
            drop_q <= 1'b0;
            if (branch_taken) begin
              pc_q   <= branch_target;
              addr_q <= branch_target;
            end else begin
              addr_q <= pc_q;
            end
          end else begin
            pc_q <= addr_q + STEP;
            if (has_room) begin
              addr_q <= addr_q + STEP;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_issue.sv
// Bench for ifetch_issue: program-order scoreboard fed by directed and random
// memory/branch/reset stimulus, checked by a decoupled monitor on the falling edge.
module tb_ifetch_issue;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [31:0] instr_pc;

  ifetch_issue #(.ADDR_W(32), .DEPTH(2), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dec_ready(dec_ready), .dec_valid(dec_valid),
    .instr(instr), .opcode(opcode), .func(func), .imm16(imm16),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] nextPc = RESET_PC;
  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;
  int          readyPct = 100;
  int          fixedDelay = 0;
  int          delayLeft = 0;
  bit          pending = 1'b0;
  bit          started = 1'b0;
  bit          holdPrev = 1'b0;
  logic [31:0] holdAddr = '0;
  logic        preValid = 1'b0;

  // Instruction memory contents; address 0 holds a known R-type word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A4_2020;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  function automatic void refill();
    exp_t e;
    while (expQ.size() < 8) begin
      e.pc   = nextPc;
      e.word = memWord(nextPc);
      expQ.push_back(e);
      nextPc = nextPc + 32'd4;
    end
  endfunction

  function automatic void restartStream(input logic [31:0] pc);
    expQ.delete();
    nextPc = pc;
    refill();
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // One clock of stimulus: reset/branch/decoder-ready plus the memory responder.
  task automatic applyStimulus(input bit doRst, input bit doBranch, input logic [31:0] target);
    bit newReq;
    @(posedge clk);
    #1;
    if (holdPrev) begin
      checkOutput("req_held", 64'(imem_req), 64'(1));
      checkOutput("addr_held", 64'(imem_addr), 64'(holdAddr));
    end
    preValid      = dec_valid;
    rst           = doRst;
    branch_taken  = doBranch && !doRst;
    branch_target = doBranch ? target : ($urandom & 32'hFFFF_FFFC);
    dec_ready     = !doRst && (int'($urandom_range(99)) < readyPct);
    newReq        = 1'b0;
    if (doRst) begin
      pending  = 1'b0;
      imem_ack = 1'b0;
      restartStream(RESET_PC);
    end else begin
      if (doBranch) restartStream(target);
      if (imem_req === 1'b1) begin
        if (!pending) begin
          pending   = 1'b1;
          newReq    = 1'b1;
          delayLeft = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(3));
        end
        if (delayLeft == 0) begin
          imem_ack = 1'b1;
          pending  = 1'b0;
        end else begin
          imem_ack = 1'b0;
          delayLeft--;
        end
      end else begin
        imem_ack = 1'b0;
        pending  = 1'b0;
      end
    end
    imem_rdata = imem_ack ? memWord(imem_addr) : $urandom;
    holdPrev   = !doRst && (imem_req === 1'b1) && !imem_ack;
    holdAddr   = imem_addr;
    started    = newReq;
    refill();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && branch_taken === 1'b1) begin
      checkOutput("valid_in_branch", 64'(dec_valid), 64'(0));
    end
    if (rst === 1'b0 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_issue: got pc 0x%0h expected none", instr_pc);
      end else begin
        e = expQ.pop_front();
        checkOutput("instr_pc", 64'(instr_pc), 64'(e.pc));
        checkOutput("instr", 64'(instr), 64'(e.word));
        checkOutput("opcode", 64'(opcode), 64'(e.word[31:26]));
        checkOutput("func", 64'(func), 64'(e.word[5:0]));
        checkOutput("imm16", 64'(imm16), 64'(e.word[15:0]));
        delivered++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          found;
    int          startDelivered;
    int          r;
    bit          doR;
    bit          doB;
    logic [31:0] tgt;

    // Reset and streaming start-up with immediate acks.
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("rst_req", 64'(imem_req), 64'(0));
    checkOutput("rst_addr", 64'(imem_addr), 64'(0));
    checkOutput("rst_valid", 64'(dec_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("c1_req", 64'(imem_req), 64'(1));
    checkOutput("c1_addr", 64'(imem_addr), 64'(32'h0));
    checkOutput("c1_valid", 64'(dec_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("c2_addr", 64'(imem_addr), 64'(32'h4));
    checkOutput("c2_valid", 64'(dec_valid), 64'(1));
    checkOutput("c2_pc", 64'(instr_pc), 64'(32'h0));
    checkOutput("c2_opcode", 64'(opcode), 64'(0));
    checkOutput("c2_func", 64'(func), 64'(32));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("c3_addr", 64'(imem_addr), 64'(32'h8));

    // Decoder stall fills the FIFO and halts fetching.
    readyPct = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("full_req", 64'(imem_req), 64'(0));
    checkOutput("full_valid", 64'(dec_valid), 64'(1));
    readyPct = 100;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (imem_req === 1'b1) found = 1'b1;
    end
    checkOutput("resume_req", 64'(found), 64'(1));

    // Branch during a slow fetch: old word dropped, redirect to 0x100.
    fixedDelay = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (started && !imem_ack) found = 1'b1;
    end
    checkOutput("slow_req_seen", 64'(found), 64'(1));
    applyStimulus(1'b0, 1'b1, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (imem_ack) found = 1'b1;
    end
    checkOutput("slow_ack_seen", 64'(found), 64'(1));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("redirect_addr", 64'(imem_addr), 64'(32'h100));

    // Branch coincident with an ack and a ready decoder.
    fixedDelay = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'h40);
    checkOutput("coinc_pre_valid", 64'(preValid), 64'(1));
    checkOutput("coinc_ack", 64'(imem_ack), 64'(1));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("coinc_valid", 64'(dec_valid), 64'(0));
    checkOutput("coinc_addr", 64'(imem_addr), 64'(32'h40));
    checkOutput("coinc_req", 64'(imem_req), 64'(1));

    // Address wrap at the top of the address space.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wrap_addr0", 64'(imem_addr), 64'(32'hFFFF_FFF8));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wrap_addr1", 64'(imem_addr), 64'(32'hFFFF_FFFC));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("wrap_addr2", 64'(imem_addr), 64'(32'h0));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0);

    // Reset while stalled with a request outstanding.
    readyPct   = 0;
    fixedDelay = 6;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("mid_rst_req", 64'(imem_req), 64'(0));
    checkOutput("mid_rst_valid", 64'(dec_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("mid_rst_restart_req", 64'(imem_req), 64'(1));
    checkOutput("mid_rst_restart_addr", 64'(imem_addr), 64'(RESET_PC));

    // Random mix of ack delays, stalls, branches and resets.
    readyPct       = 70;
    fixedDelay     = -1;
    startDelivered = delivered;
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(99));
      doR = (r < 1);
      doB = !doR && (r < 7);
      tgt = ($urandom_range(1) != 0) ? 32'h0000_0000 : 32'hFFFF_FF00;
      tgt = tgt | (32'($urandom_range(63)) << 2);
      applyStimulus(doR, doB, tgt);
    end
    readyPct = 100;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("random_progress", 64'((delivered - startDelivered) >= 50), 64'(1));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_issue.md
Name: ifetch_issue

Overview:
- Instruction fetch/issue stage: the producer side of the control decoder's interface.
- Holds the program counter and issues word fetches to instruction memory with a req/ack handshake.
- Buffers fetched words in a small FIFO and presents opcode/func/imm fields plus PC to the decoder over a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding any in-flight fetch.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DEPTH, 2, FIFO entries (power of two, ≥2).
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request (registered).
- imem_addr  out  ADDR_W  fetch address (registered); stable while imem_req=1.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- branch_taken  in  1  one-cycle redirect pulse from execute.
- branch_target  in  ADDR_W  redirect PC; sampled when branch_taken=1.
- dec_ready  in  1  decoder accepts the head entry.
- dec_valid  out  1  head entry valid.
- instr  out  32  head instruction word.
- opcode  out  6  instr[31:26].
- func  out  6  instr[5:0].
- imm16  out  16  instr[15:0].
- instr_pc  out  ADDR_W  PC of the head instruction.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, drop=0, FIFO count=0, read/write pointers=0. FIFO storage is not reset. rst overrides every other input.
- Interface requirement: dec_valid=0 throughout reset and in the first cycle after reset.
- dec_valid = (count!=0) & ~branch_taken. This is the only combinational path from an input.
- instr/opcode/func/imm16/instr_pc are driven from the FIFO head. Their value is don't-care when dec_valid=0.
- pop = dec_valid & dec_ready.
- push = (state==REQ) & imem_ack & ~drop & ~branch_taken. Entry is {imem_addr, imem_rdata}.
- count_after = count + push − pop, computed before any flush.
- State IDLE:
  - If branch_taken: pc=branch_target.
  - Else if count_after<DEPTH: go to REQ, imem_req=1, imem_addr=pc.
- State REQ, hold (imem_ack=0):
  - imem_req and imem_addr hold.
  - If branch_taken: drop=1, pc=branch_target. The newest target wins if branches repeat.
- State REQ, ack received:
  - If drop=1 or branch_taken=1: word discarded, drop=0. Next imem_addr = target (branch_target if branch_taken this cycle, else stored pc); stay REQ.
  - Otherwise: pc=imem_addr+4, modulo 2^ADDR_W (wraps to 0). If count_after<DEPTH, stay REQ with imem_addr=pc+4; else go IDLE, imem_req=0.
- Back-to-back acks sustain one instruction per cycle when the decoder is ready.
- Latency: first imem_req in cycle 1 after reset release. Ack in that cycle gives dec_valid in cycle 2.
- Flush (branch_taken=1): FIFO count=0 and pointers reset at the edge. The head is not transferred in the branch cycle, even if dec_ready=1. Queued entries are dropped.
- Full FIFO: no new request is issued. Push and pop in the same cycle are legal when count<DEPTH.
- Empty FIFO with dec_ready=1: no pop, no underflow.
- At most one outstanding request at any time.

Test Plan:
- Reset, RESET_PC=0x0, memory acks every request immediately, dec_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; dec_valid from cycle 2; instr_pc 0x0,0x4,0x8; opcode/func match instr[31:26]/[5:0] (e.g. 0x00A4_2020 gives opcode 0, func 32).
- dec_ready=0 → FIFO holds 2 entries (PC 0x0,0x4), imem_req drops to 0. Raise dec_ready → 0x0 then 0x4 pop, fetching resumes at 0x8.
- Memory with 3-cycle ack delay, branch_taken at delay cycle 1 with target 0x100 -> old word at 0x8 discarded, next imem_addr=0x100, first dec_valid entry has instr_pc=0x100.
- branch_taken coincident with imem_ack and dec_valid&dec_ready, target 0x40 -> no push, head not consumed, count=0, next imem_addr=0x40.
- RESET_PC=0xFFFF_FFF8, streaming -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- rst asserted for one cycle while REQ outstanding with full FIFO -> next cycle imem_req=0, dec_valid=0; fetch restarts at RESET_PC.
